// File: rtl/fpu_issue_sequencer.sv
// Issue sequencer for variable-latency FPU ops in the EX/MEM stage: classifies latency,
// stalls upstream while an op is in flight and emits a one-cycle float-register writeback.
module fpu_issue_sequencer #(
  parameter int LAT_ADD  = 2,
  parameter int LAT_MUL  = 3,
  parameter int LAT_DIV  = 10,
  parameter int LAT_SQRT = 12,
  parameter int LAT_CVT  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        issue_valid,
  input  logic [4:0]  selFPU,
  input  logic [4:0]  rd,
  input  logic        flush,
  input  logic [31:0] fpu_result,
  output logic        op_latch,
  output logic        stall,
  output logic        busy,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data
);

  // Handshake: an op transfers in any cycle where issue_valid=1 and stall=0 and flush=0;
  // while stall=1 upstream keeps the same op presented and it is not consumed.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [4:0]  pendRd;
  logic [3:0]  opLat;
  logic        cntZero;
  logic        multiCycle;
  logic        accept;
  logic        complete;

  function automatic logic [3:0] latencyOf(input logic [4:0] sel);
    case (sel)
      5'd0, 5'd1: latencyOf = 4'(LAT_ADD);
      5'd6:       latencyOf = 4'(LAT_MUL);
      5'd7:       latencyOf = 4'(LAT_DIV);
      5'd8:       latencyOf = 4'(LAT_SQRT);
      5'd14:      latencyOf = 4'(LAT_CVT);
      default:    latencyOf = 4'd1;
    endcase
  endfunction

  always_comb begin
    opLat      = latencyOf(selFPU);
    cntZero    = (cnt == 4'd0);
    multiCycle = (opLat > 4'd1);
    accept     = rst_n & issue_valid & ~flush & ((state == IDLE) | cntZero);
    complete   = (state == BUSY) & cntZero & ~flush;
    stall      = rst_n & ~flush & ((accept & multiCycle) | ((state == BUSY) & ~cntZero));
    op_latch   = accept;
    busy       = (state == BUSY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      pendRd   <= 5'd0;
      wb_valid <= 1'b0;
      wb_rd    <= 5'd0;
      wb_data  <= 32'd0;
    end else begin
      wb_valid <= 1'b0;
      if (flush) begin
        state <= IDLE;
        cnt   <= 4'd0;
      end else begin
        if ((state == BUSY) && !cntZero) begin
          cnt <= cnt - 4'd1;
        end
        if (complete) begin
          wb_valid <= 1'b1;
          wb_rd    <= pendRd;
          wb_data  <= fpu_result;
          state    <= IDLE;
        end
        if (accept) begin
          if (multiCycle) begin
            state  <= BUSY;
            cnt    <= opLat - 4'd2;
            pendRd <= rd;
          end else if (complete) begin
            // The writeback port is taken this cycle, so a single-cycle op arriving in a
            // completion cycle is held one cycle and retires through the BUSY/cnt==0 path.
            state  <= BUSY;
            cnt    <= 4'd0;
            pendRd <= rd;
          end else begin
            wb_valid <= 1'b1;
            wb_rd    <= rd;
            wb_data  <= fpu_result;
            state    <= IDLE;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_fpu_issue_sequencer.sv
// Directed bench for fpu_issue_sequencer: reset, single-cycle op, fmul, back-to-back,
// flush and asynchronous reset mid-op, each with hand-computed expectations.
module tb_fpu_issue_sequencer;

  logic        clk;
  logic        rst_n;
  logic        issue_valid;
  logic [4:0]  selFPU;
  logic [4:0]  rd;
  logic        flush;
  logic [31:0] fpu_result;
  logic        op_latch;
  logic        stall;
  logic        busy;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int total;
  int bad;

  fpu_issue_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .issue_valid(issue_valid),
    .selFPU     (selFPU),
    .rd         (rd),
    .flush      (flush),
    .fpu_result (fpu_result),
    .op_latch   (op_latch),
    .stall      (stall),
    .busy       (busy),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge; inputs are driven here, checks follow #2.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    issue_valid = 1'b1;
    selFPU      = 5'd6;
    rd          = 5'd3;
    flush       = 1'b0;
    fpu_result  = 32'hDEADBEEF;
    step();
    step();
    #2;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%0b want=0", stall); end
    total++; if (op_latch !== 1'b0) begin bad++; $display("FAIL reset_op_latch got=%0b want=0", op_latch); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL reset_wb_valid got=%0b want=0", wb_valid); end
    total++; if (wb_rd !== 5'd0) begin bad++; $display("FAIL reset_wb_rd got=%0d want=0", wb_rd); end
    total++; if (wb_data !== 32'd0) begin bad++; $display("FAIL reset_wb_data got=%h want=0", wb_data); end
    step();
    issue_valid = 1'b0;
    rst_n       = 1'b1;
    step();
    #2;
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL reset_no_accept got=%0b want=0", wb_valid); end
  endtask

  task automatic test_fmv();
    step();
    issue_valid = 1'b1;
    selFPU      = 5'd12;
    rd          = 5'd9;
    fpu_result  = 32'h37800000;
    #2;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL fmv_stall_T got=%0b want=0", stall); end
    total++; if (op_latch !== 1'b1) begin bad++; $display("FAIL fmv_op_latch got=%0b want=1", op_latch); end
    step();
    issue_valid = 1'b0;
    fpu_result  = 32'h0;
    #2;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL fmv_stall_T1 got=%0b want=0", stall); end
    total++; if (wb_valid !== 1'b1) begin bad++; $display("FAIL fmv_wb_valid got=%0b want=1", wb_valid); end
    total++; if (wb_rd !== 5'd9) begin bad++; $display("FAIL fmv_wb_rd got=%0d want=9", wb_rd); end
    total++; if (wb_data !== 32'h37800000) begin bad++; $display("FAIL fmv_wb_data got=%h want=37800000", wb_data); end
    step();
    #2;
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL fmv_wb_pulse got=%0b want=0", wb_valid); end
    total++; if (wb_rd !== 5'd9) begin bad++; $display("FAIL fmv_wb_rd_hold got=%0d want=9", wb_rd); end
    total++; if (wb_data !== 32'h37800000) begin bad++; $display("FAIL fmv_wb_data_hold got=%h want=37800000", wb_data); end
  endtask

  task automatic test_fmul();
    step();
    issue_valid = 1'b1;
    selFPU      = 5'd6;
    rd          = 5'd1;
    fpu_result  = 32'hDEAD0000;
    #2;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL fmul_stall_T got=%0b want=1", stall); end
    total++; if (op_latch !== 1'b1) begin bad++; $display("FAIL fmul_op_latch_T got=%0b want=1", op_latch); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL fmul_busy_T got=%0b want=0", busy); end
    step();
    // An fmv presented while stalled must be ignored.
    selFPU = 5'd12;
    rd     = 5'd20;
    #2;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL fmul_stall_T1 got=%0b want=1", stall); end
    total++; if (op_latch !== 1'b0) begin bad++; $display("FAIL fmul_ignored_issue got=%0b want=0", op_latch); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL fmul_busy_T1 got=%0b want=1", busy); end
    step();
    issue_valid = 1'b0;
    fpu_result  = 32'h3F8CCD00;
    #2;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL fmul_stall_T2 got=%0b want=0", stall); end
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL fmul_wb_early got=%0b want=0", wb_valid); end
    step();
    fpu_result = 32'h11111111;
    #2;
    total++; if (wb_valid !== 1'b1) begin bad++; $display("FAIL fmul_wb_valid got=%0b want=1", wb_valid); end
    total++; if (wb_rd !== 5'd1) begin bad++; $display("FAIL fmul_wb_rd got=%0d want=1", wb_rd); end
    total++; if (wb_data !== 32'h3F8CCD00) begin bad++; $display("FAIL fmul_wb_data got=%h want=3f8ccd00", wb_data); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL fmul_busy_T3 got=%0b want=0", busy); end
    step();
    #2;
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL fmul_wb_pulse got=%0b want=0", wb_valid); end
  endtask

  task automatic test_back_to_back();
    step();
    issue_valid = 1'b1;
    selFPU      = 5'd14;
    rd          = 5'd3;
    fpu_result  = 32'h0;
    #2;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL b2b_stall_T got=%0b want=1", stall); end
    step();
    selFPU     = 5'd12;
    rd         = 5'd4;
    fpu_result = 32'h478CCD00;
    #2;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL b2b_stall_T1 got=%0b want=0", stall); end
    total++; if (op_latch !== 1'b1) begin bad++; $display("FAIL b2b_accept_T1 got=%0b want=1", op_latch); end
    step();
    issue_valid = 1'b0;
    fpu_result  = 32'h40490FDB;
    #2;
    total++; if (wb_valid !== 1'b1) begin bad++; $display("FAIL b2b_wb1_valid got=%0b want=1", wb_valid); end
    total++; if (wb_rd !== 5'd3) begin bad++; $display("FAIL b2b_wb1_rd got=%0d want=3", wb_rd); end
    total++; if (wb_data !== 32'h478CCD00) begin bad++; $display("FAIL b2b_wb1_data got=%h want=478ccd00", wb_data); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL b2b_stall_T2 got=%0b want=0", stall); end
    step();
    fpu_result = 32'h0;
    #2;
    total++; if (wb_valid !== 1'b1) begin bad++; $display("FAIL b2b_wb2_valid got=%0b want=1", wb_valid); end
    total++; if (wb_rd !== 5'd4) begin bad++; $display("FAIL b2b_wb2_rd got=%0d want=4", wb_rd); end
    total++; if (wb_data !== 32'h40490FDB) begin bad++; $display("FAIL b2b_wb2_data got=%h want=40490fdb", wb_data); end
    step();
    #2;
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL b2b_wb_end got=%0b want=0", wb_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_busy_end got=%0b want=0", busy); end
  endtask

  task automatic test_flush();
    step();
    issue_valid = 1'b1;
    selFPU      = 5'd7;
    rd          = 5'd5;
    fpu_result  = 32'hAAAA5555;
    #2;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL flush_stall_T got=%0b want=1", stall); end
    for (int k = 1; k <= 12; k++) begin
      step();
      issue_valid = 1'b0;
      flush       = 1'b0;
      if (k == 4) begin
        flush       = 1'b1;
        issue_valid = 1'b1;
        selFPU      = 5'd12;
        rd          = 5'd30;
      end else if (k == 5) begin
        issue_valid = 1'b1;
        selFPU      = 5'd0;
        rd          = 5'd6;
      end else if (k == 6) begin
        fpu_result = 32'h3FC00000;
      end else begin
        fpu_result = 32'hAAAA5555;
      end
      #2;
      if (k <= 3) begin
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL flush_stall_pre k=%0d got=%0b want=1", k, stall); end
      end
      if (k == 4) begin
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL flush_stall_cycle got=%0b want=0", stall); end
        total++; if (op_latch !== 1'b0) begin bad++; $display("FAIL flush_reject_issue got=%0b want=0", op_latch); end
      end
      if (k == 5) begin
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_busy_after got=%0b want=0", busy); end
        total++; if (op_latch !== 1'b1) begin bad++; $display("FAIL flush_next_accept got=%0b want=1", op_latch); end
      end
      total++;
      if (wb_valid !== (k == 7)) begin
        bad++; $display("FAIL flush_wb_valid k=%0d got=%0b want=%0b", k, wb_valid, (k == 7));
      end
      if (k == 7) begin
        total++; if (wb_rd !== 5'd6) begin bad++; $display("FAIL flush_fadd_rd got=%0d want=6", wb_rd); end
        total++; if (wb_data !== 32'h3FC00000) begin bad++; $display("FAIL flush_fadd_data got=%h want=3fc00000", wb_data); end
      end
    end
  endtask

  task automatic test_reset_midop();
    step();
    issue_valid = 1'b1;
    selFPU      = 5'd8;
    rd          = 5'd7;
    fpu_result  = 32'hCAFEF00D;
    for (int k = 1; k <= 6; k++) begin
      step();
      issue_valid = 1'b0;
    end
    #2;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rst_mid_busy_pre got=%0b want=1", busy); end
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL rst_mid_stall_pre got=%0b want=1", stall); end
    rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy_async got=%0b want=0", busy); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL rst_mid_stall_async got=%0b want=0", stall); end
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      #2;
      total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_no_wb k=%0d got=%0b want=0", k, wb_valid); end
    end
    step();
    issue_valid = 1'b1;
    selFPU      = 5'd12;
    rd          = 5'd10;
    fpu_result  = 32'h12345678;
    #2;
    total++; if (op_latch !== 1'b1) begin bad++; $display("FAIL rst_mid_fmv_accept got=%0b want=1", op_latch); end
    step();
    issue_valid = 1'b0;
    #2;
    total++; if (wb_valid !== 1'b1) begin bad++; $display("FAIL rst_mid_fmv_wb got=%0b want=1", wb_valid); end
    total++; if (wb_rd !== 5'd10) begin bad++; $display("FAIL rst_mid_fmv_rd got=%0d want=10", wb_rd); end
    total++; if (wb_data !== 32'h12345678) begin bad++; $display("FAIL rst_mid_fmv_data got=%h want=12345678", wb_data); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_fmv();
    test_fmul();
    test_back_to_back();
    test_flush();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
